axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

Synthesizable AXI3 slave memory: the responder end of the 32-bit, 4-bit-ID AXI bus that the master driver and protocol checkers sit on. Accepts one write burst and one read burst at a time (independent channels), supports FIXED/INCR/WRAP, sizes 1/2/4 bytes, lengths 1–16, and returns OKAY/SLVERR. It serves as the DUT behind the master VIP and as the memory model in subsystem benches.

## Interface
- MEM_DEPTH, 1024: memory size in 32-bit words; word index = addr[31:2].
- clk  in  1  clock, all activity on posedge.
- rst  in  1  synchronous, active-high reset.
- awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/4/3/2/1  write address channel.
- awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel.
- wready  out  1.
- bid/bresp/bvalid  out  4/2/1;  bready  in  1.
- arid/araddr/arlen/arsize/arburst/arvalid  in  4/32/4/3/2/1.
- arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1;  rready  in  1.

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. Read FSM R_IDLE -> R_DATA -> R_IDLE. Channels fully independent.
- W_IDLE: awready=1. AW handshake captures id, addr, len, size, burst; beat count cleared; error flag set if burst==3, size>2, WRAP with len not in {1,3,7,15}, or WRAP with addr not aligned to 1<<size.
- W_DATA: wready=1. Each W handshake writes wdata byte lanes enabled by wstrb into mem[addr[31:2]] if word index < MEM_DEPTH and no decode error; otherwise write dropped, error flag set. wid ignored for addressing; wid != captured awid sets error.
- Burst terminates on beat len+1 regardless of wlast; wlast on an earlier beat, or missing on beat len+1, sets error.
- W_RESP: bvalid=1, bid=captured awid, bresp=2'b10 (SLVERR) if error else 2'b00; held stable until bready.
- R_IDLE: arready=1. AR handshake captures fields, same decode-error rules.
- R_DATA: rvalid=1, rid=captured arid, rdata=mem word at current beat address (0 if out of range or decode error), rresp SLVERR per beat for such beats else OKAY, rlast=1 only on beat len+1. Outputs stable while rvalid && !rready.
- Address step after each beat (both channels): FIXED: unchanged. INCR: addr + (1<<size). WRAP: boundary = (len+1)<<size; next = (addr & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)). 32-bit arithmetic, INCR wraps modulo 2^32.
- Narrow transfers: write uses wstrb as given; read returns full 32-bit word.

## Timing
- Reset (rst=1 at posedge): both FSMs to IDLE; awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. awready and arready rise the cycle after rst deasserts. Memory contents not reset. Reset mid-burst abandons the burst; no response issued.
- All outputs registered.
- AW handshake at edge N: awready=0, wready=1 from N+1. Final W beat at edge M: wready=0, bvalid=1 from M+1. B handshake at edge K: awready=1 from K+1. Minimum write burst of 1 beat: 3 cycles AW-to-next-awready with ready master.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1. Each R handshake loads next beat for the following cycle (one beat per cycle with rready held high). Last beat accepted at edge L: rvalid=0, rlast=0 from L+1, arready=1 from L+1; rvalid therefore low ≥1 cycle after every rlast.
- Same-edge write and read of one word: read register captures the pre-write value.
- awready/arready never asserted while their FSM is busy; valid outputs never drop without handshake.

## Test plan
- Reset: hold rst 3 cycles mid-read-burst -> all outputs 0, then arready=1, awready=1 one cycle after release; no stray rvalid.
- INCR write awaddr=0x100, awlen=3, size=2, wdata 0xA0..0xA3, wstrb=4'hF -> bvalid with bresp=OKAY, bid=awid; INCR read same -> 0xA0..0xA3, rlast on beat 4 only, rvalid low next cycle.
- WRAP read araddr=0x108, arlen=3, size=2 -> beat addresses 0x108, 0x10C, 0x100, 0x104.
- Backpressure: rready toggling 1/0, bready held low 5 cycles -> rdata/rid/rlast and bvalid/bresp stable while stalled, no beat lost or duplicated.
- Errors: awburst=3 -> SLVERR, memory unchanged; araddr=MEM_DEPTH*4 -> rresp=SLVERR, rdata=0; early wlast on beat 2 of awlen=3 -> burst still takes 4 beats, bresp=SLVERR.
- Strobes/narrow: write 0xFFFFFFFF then wstrb=4'b0010 with 0x0000AB00 -> read 0xFFFFABFF.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory: one write burst and one read burst in flight at a time.
// The two channels run independently. Supports FIXED/INCR/WRAP bursts, sizes 1/2/4 bytes
// and lengths 1-16. Decode errors and out-of-range beats are answered with SLVERR.
module axi_slave_mem #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned IdxW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0] DepthW = 30'(MEM_DEPTH);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Reserved burst type, oversize beat, illegal WRAP length or misaligned WRAP start.
    function automatic logic decode_err(input logic [31:0] addr, input logic [3:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] align_mask;
        logic        len_ok;
        align_mask = (32'd1 << size) - 32'd1;
        len_ok     = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (burst == 2'b11) || (size > 3'd2) ||
               ((burst == 2'b10) && (!len_ok || ((addr & align_mask) != 32'd0)));
    endfunction

    // Address of the beat following the one at addr.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] bound;
        logic [31:0] res;
        step  = 32'd1 << size;
        bound = ({28'd0, len} + 32'd1) << size;
        case (burst)
            2'b01:   res = addr + step;
            2'b10:   res = (addr & ~(bound - 32'd1)) | ((addr + step) & (bound - 32'd1));
            default: res = addr;
        endcase
        return res;
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:2] < DepthW;
    endfunction

    logic [31:0] mem [MEM_DEPTH];

    // ---------------- write channel state ----------------
    w_state_e    w_state_q, w_state_d;
    logic        awready_q, wready_q, bvalid_q;
    logic [3:0]  bid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  aw_id_q;
    logic [31:0] w_addr_q;
    logic [3:0]  w_len_q;
    logic [2:0]  w_size_q;
    logic [1:0]  w_burst_q;
    logic [3:0]  w_cnt_q;
    logic        w_dec_q;
    logic        w_err_q;

    logic            aw_hs, w_hs, b_hs;
    logic            w_last_beat, w_beat_err, mem_we, aw_dec;
    logic [IdxW-1:0] w_idx;

    assign aw_hs       = awvalid && awready_q;
    assign w_hs        = wvalid && wready_q;
    assign b_hs        = bready && bvalid_q;
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign aw_dec      = decode_err(awaddr, awlen, awsize, awburst);
    assign w_idx       = w_addr_q[IdxW+1:2];
    // wid mismatch flags the burst but does not stop the data landing in memory.
    assign mem_we      = w_hs && !w_dec_q && in_range(w_addr_q);
    assign w_beat_err  = (wlast != w_last_beat) || (wid != aw_id_q) || w_dec_q ||
                         !in_range(w_addr_q);

    // Write FSM next state.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle:   if (aw_hs) w_state_d = WData;
            WData:   if (w_hs && w_last_beat) w_state_d = WResp;
            WResp:   if (b_hs) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    // Write FSM state, registered channel outputs and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RespOkay;
            aw_id_q   <= 4'd0;
            w_addr_q  <= 32'd0;
            w_len_q   <= 4'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'd0;
            w_cnt_q   <= 4'd0;
            w_dec_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == WIdle);
            wready_q  <= (w_state_d == WData);
            bvalid_q  <= (w_state_d == WResp);
            if (aw_hs) begin
                aw_id_q   <= awid;
                w_addr_q  <= awaddr;
                w_len_q   <= awlen;
                w_size_q  <= awsize;
                w_burst_q <= awburst;
                w_cnt_q   <= 4'd0;
                w_dec_q   <= aw_dec;
                w_err_q   <= aw_dec;
            end else if (w_hs) begin
                w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                w_cnt_q  <= w_cnt_q + 4'd1;
                if (w_beat_err) w_err_q <= 1'b1;
                if (w_last_beat) begin
                    bid_q   <= aw_id_q;
                    bresp_q <= (w_err_q || w_beat_err) ? RespSlvErr : RespOkay;
                end
            end
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel state ----------------
    r_state_e    r_state_q, r_state_d;
    logic        arready_q, rvalid_q, rlast_q;
    logic [3:0]  rid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] r_addr_q;   // address of the beat after the one presented
    logic [3:0]  r_len_q;
    logic [2:0]  r_size_q;
    logic [1:0]  r_burst_q;
    logic [3:0]  r_cnt_q;    // index of the beat presented on the bus
    logic        r_dec_q;

    logic            ar_hs, r_hs, r_last_beat, ar_dec, ld_next;
    logic [31:0]     ld_addr, ld_data, ld_next_addr;
    logic [3:0]      ld_len;
    logic [2:0]      ld_size;
    logic [1:0]      ld_burst;
    logic            ld_dec, ld_ok, ld_last;
    logic [IdxW-1:0] ld_idx;

    assign ar_hs       = arvalid && arready_q;
    assign r_hs        = rvalid_q && rready;
    assign r_last_beat = (r_cnt_q == r_len_q);
    assign ar_dec      = decode_err(araddr, arlen, arsize, arburst);
    assign ld_next     = r_hs && !r_last_beat;

    // Select the beat to load: beat 0 on AR handshake, otherwise the following beat.
    always_comb begin
        ld_addr  = ar_hs ? araddr  : r_addr_q;
        ld_len   = ar_hs ? arlen   : r_len_q;
        ld_size  = ar_hs ? arsize  : r_size_q;
        ld_burst = ar_hs ? arburst : r_burst_q;
        ld_dec   = ar_hs ? ar_dec  : r_dec_q;
        ld_last  = ar_hs ? (arlen == 4'd0) : ((r_cnt_q + 4'd1) == r_len_q);
        ld_ok    = !ld_dec && in_range(ld_addr);
        ld_idx   = ld_addr[IdxW+1:2];
        ld_data  = ld_ok ? mem[ld_idx] : 32'd0;
        ld_next_addr = next_addr(ld_addr, ld_len, ld_size, ld_burst);
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle: if (ar_hs) r_state_d = RData;
            RData: if (r_hs && r_last_beat) r_state_d = RIdle;
        endcase
    end

    // Read FSM state and registered R channel; the data register samples the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RespOkay;
            r_addr_q  <= 32'd0;
            r_len_q   <= 4'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'd0;
            r_cnt_q   <= 4'd0;
            r_dec_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == RIdle);
            if (ar_hs) begin
                rid_q     <= arid;
                r_len_q   <= arlen;
                r_size_q  <= arsize;
                r_burst_q <= arburst;
                r_dec_q   <= ar_dec;
                r_cnt_q   <= 4'd0;
            end else if (ld_next) begin
                r_cnt_q <= r_cnt_q + 4'd1;
            end
            if (ar_hs || ld_next) begin
                rvalid_q <= 1'b1;
                rdata_q  <= ld_data;
                rresp_q  <= ld_ok ? RespOkay : RespSlvErr;
                rlast_q  <= ld_last;
                r_addr_q <= ld_next_addr;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: drivers push expected B/R responses computed from a
// word-array memory model; a negedge monitor pops and compares every handshake.
module tb_axi_slave_mem;
    localparam int unsigned MemDepth = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    axi_slave_mem #(.MEM_DEPTH(MemDepth)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] ref_mem [MemDepth];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Burst legality straight from the protocol rules.
    function automatic bit legal(input logic [31:0] addr, input int len, input int size,
                                 input int burst);
        int unsigned a;
        a = addr;
        if (burst == 3 || size > 2) return 1'b0;
        if (burst == 2) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
            if ((a % (32'd1 << size)) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Address of beat i computed directly (not by stepping).
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int len,
                                              input int size, input int burst, input int i);
        longint unsigned a, step, bound, base;
        a    = addr;
        step = 64'd1 << size;
        if (burst == 1) return 32'(a + longint'(i) * step);
        if (burst == 2) begin
            bound = longint'(len + 1) * step;
            base  = a - (a % bound);
            return 32'(base + ((a - base + longint'(i) * step) % bound));
        end
        return addr;
    endfunction

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int size, input int burst, input int flip_beat,
                               input bit bad_wid, input int bstall);
        bit          dec, err, inr, lst;
        logic [31:0] a;
        int          n;
        b_exp_t      e;
        dec = !legal(addr, len, size, burst);
        err = dec || bad_wid;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            inr = (a[31:2] < MemDepth);
            lst = (i == len) ^ (i == flip_beat);
            if (lst != (i == len) || !inr) err = 1'b1;
            if (!dec && inr) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[int'(a[31:2])][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(e);

        awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 200);
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1;
            wid    = bad_wid ? ~id : id;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == len) ^ (i == flip_beat);
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 200);
            if (!wready) timeout("w_handshake");
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b0;
        repeat (bstall) begin @(posedge clk); #1; end
        bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 200);
        if (!bvalid) timeout("b_handshake");
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    // mode 0: rready high, 1: toggling, 2: random
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input int burst, input int mode);
        bit          dec, ok;
        logic [31:0] a;
        int          n, got;
        r_exp_t      e;
        dec = !legal(addr, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, len, size, burst, i);
            ok     = !dec && (a[31:2] < MemDepth);
            e.id   = id;
            e.data = ok ? ref_mem[int'(a[31:2])] : 32'd0;
            e.resp = ok ? 2'b00 : 2'b10;
            e.last = (i == len);
            r_q.push_back(e);
        end
        arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 200);
        if (!arready) timeout("ar_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0;
        n   = 0;
        while (got <= len && n < 500) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = n[0];
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (rvalid && rready) got++;
            n++;
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (got <= len) timeout("r_beats");
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp,
                                bid, rid, rdata}, 64'd0);
        r_q.delete();
        b_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", {awready, arready}, 64'd0);
        @(negedge clk);
        check("ready_after_reset", {awready, arready, rvalid, bvalid}, 64'b1100);
        repeat (3) begin
            @(negedge clk);
            check("no_stray_rvalid", {rvalid, bvalid}, 64'd0);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops expected responses on every handshake, checks stall stability.
    logic        hold_r = 1'b0, hold_b = 1'b0, prev_last = 1'b0;
    logic [38:0] snap_r;
    logic [5:0]  snap_b;
    always @(negedge clk) begin
        r_exp_t re;
        b_exp_t be;
        if (rst) begin
            hold_r    = 1'b0;
            hold_b    = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (prev_last) check("rvalid_after_rlast", {rvalid, rlast}, 64'd0);
            prev_last = 1'b0;
            if (hold_r) check("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, snap_r});
            hold_r = 1'b0;
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    timeout("r_unexpected_beat");
                end else begin
                    re = r_q.pop_front();
                    check("r_beat", {rid, rdata, rresp, rlast},
                          {re.id, re.data, re.resp, re.last});
                    prev_last = rlast;
                end
            end else if (rvalid) begin
                hold_r = 1'b1;
                snap_r = {rid, rdata, rresp, rlast};
            end
            if (hold_b) check("b_stable", {bvalid, bid, bresp}, {1'b1, snap_b});
            hold_b = 1'b0;
            if (bvalid && bready) begin
                if (b_q.size() == 0) begin
                    timeout("b_unexpected_resp");
                end else begin
                    be = b_q.pop_front();
                    check("b_resp", {bid, bresp}, {be.id, be.resp});
                end
            end else if (bvalid) begin
                hold_b = 1'b1;
                snap_b = {bid, bresp};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, size, burst, len, flip;
        logic [31:0] addr;

        reset_dut();

        // Fill the whole memory so every in-range read has a known model value.
        for (int k = 0; k < int'(MemDepth) / 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'hF;
            end
            write_burst(4'(k), 32'(k * 64), 15, 2, 1, -1, 1'b0, 0);
        end

        // INCR write then read back.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i);
            ws[i] = 4'hF;
        end
        write_burst(4'd5, 32'h100, 3, 2, 1, -1, 1'b0, 0);
        read_burst(4'd6, 32'h100, 3, 2, 1, 0);

        // WRAP read starting mid-window, toggling rready.
        read_burst(4'd7, 32'h108, 3, 2, 2, 1);

        // bready stalled 5 cycles.
        for (int i = 0; i < 2; i++) begin
            wd[i] = 32'h1234_0000 + 32'(i);
            ws[i] = 4'hF;
        end
        write_burst(4'd9, 32'h180, 1, 2, 1, -1, 1'b0, 5);
        read_burst(4'd9, 32'h180, 1, 2, 1, 1);

        // Reserved burst type: SLVERR and memory untouched.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hDEAD_BEEF;
            ws[i] = 4'hF;
        end
        write_burst(4'd2, 32'h100, 3, 2, 3, -1, 1'b0, 0);
        read_burst(4'd2, 32'h100, 3, 2, 1, 0);

        // Read just past the end of memory.
        read_burst(4'd4, 32'(MemDepth * 4), 0, 2, 1, 0);

        // Early wlast on beat 2 of a 4-beat burst.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hC0 + 32'(i);
            ws[i] = 4'hF;
        end
        write_burst(4'd8, 32'h140, 3, 2, 1, 1, 1'b0, 0);
        read_burst(4'd8, 32'h140, 3, 2, 1, 0);

        // Byte strobe merge.
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        write_burst(4'd1, 32'h200, 0, 2, 1, -1, 1'b0, 0);
        wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
        write_burst(4'd1, 32'h200, 0, 2, 1, -1, 1'b0, 1);
        read_burst(4'd1, 32'h200, 0, 2, 1, 0);

        // Reset in the middle of a stalled read burst.
        araddr = 32'h100; arlen = 4'd15; arsize = 3'd2; arburst = 2'd1; arid = 4'd3;
        arvalid = 1'b1;
        rready  = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 200);
        if (!arready) timeout("ar_before_reset");
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_dut();
        read_burst(4'd3, 32'h100, 3, 2, 1, 0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0:       len = 1;
                    1:       len = 3;
                    2:       len = 7;
                    3:       len = 15;
                    default: len = 2;
                endcase
            end else begin
                len = int'($urandom_range(0, 15));
            end
            addr = 32'($urandom_range(0, MemDepth * 4 - 1));
            if (size <= 2) addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = 32'(MemDepth * 4 - 8);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom_range(0, 15));
                end
                flip = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
                write_burst(4'($urandom_range(0, 15)), addr, len, size, burst, flip,
                            1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
            end else begin
                read_burst(4'($urandom_range(0, 15)), addr, len, size, burst,
                           int'($urandom_range(0, 2)));
            end
        end

        repeat (3) @(posedge clk);
        if (r_q.size() != 0 || b_q.size() != 0) timeout("scoreboard_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
